// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: buffers 3-bit codes in a small FIFO and shows each one
// as an MSB-first one-hot word (code 0 -> bit 7, code 7 -> bit 0) for HOLD
// cycles. Consecutive queued words are shown back to back with no gap.
module onehot_decoder_seq #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [2:0]               in_code,
  output logic                     in_ready,
  output logic [7:0]               out,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] HOLD_M1  = CW'(HOLD - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t        state;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          full, empty, push, pop;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  // No full-bypass: a pop in the same cycle does not open the input.
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  // The FSM takes the head whenever it is idle or the current word's hold expires.
  assign pop      = !empty && !rst && ((state == IDLE) || (cnt == '0));

  // Storage write; in_code only sampled on an accepted transfer.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end

  // Pointers and occupancy; push+pop together leave level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Display FSM with registered one-hot output and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out       <= 8'h00;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            out       <= 8'h80 >> mem[rd_ptr];
            out_valid <= 1'b1;
            cnt       <= HOLD_M1;
            state     <= SHOW;
          end
        end
        SHOW: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (pop) begin
            out <= 8'h80 >> mem[rd_ptr];
            cnt <= HOLD_M1;
          end else begin
            out       <= 8'h00;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
